// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/execute/writeback signal bundle around the decode stage
interface decode_stage_if #(
   parameter int INSTR_W = 16,
   parameter int REG_AW  = 2,
   parameter int IMM_W   = INSTR_W - 4 - 2*REG_AW
);
   localparam int NREG = 2**REG_AW;

   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] instruction;
   logic               out_valid;
   logic               out_ready;
   logic               reg_write;
   logic               reg_dst;
   logic               alu_src_a;
   logic               alu_src_b;
   logic               mem_write;
   logic               mem_to_reg;
   logic [2:0]         alu_op;
   logic [3:0]         opcode;
   logic [REG_AW-1:0]  rs_addr;
   logic [REG_AW-1:0]  rt_addr;
   logic [REG_AW-1:0]  rd_addr;
   logic [IMM_W-1:0]   imm;
   logic               wb_valid;
   logic [REG_AW-1:0]  wb_addr;
   logic               flush;
   logic               illegal_seen;
   logic [NREG-1:0]    pending;

   modport master (
      output in_valid, instruction, out_ready, wb_valid, wb_addr, flush,
      input  in_ready, out_valid, reg_write, reg_dst, alu_src_a, alu_src_b,
             mem_write, mem_to_reg, alu_op, opcode, rs_addr, rt_addr, rd_addr,
             imm, illegal_seen, pending
   );

   modport slave (
      input  in_valid, instruction, out_ready, wb_valid, wb_addr, flush,
      output in_ready, out_valid, reg_write, reg_dst, alu_src_a, alu_src_b,
             mem_write, mem_to_reg, alu_op, opcode, rs_addr, rt_addr, rd_addr,
             imm, illegal_seen, pending
   );
endinterface

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode stage with RAW/WAW scoreboard
module decode_stage #(
   parameter int INSTR_W = 16,
   parameter int REG_AW  = 2,
   parameter int IMM_W   = INSTR_W - 4 - 2*REG_AW
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);
   localparam int NREG   = 2**REG_AW;
   localparam int OP_LSB = INSTR_W - 4;
   localparam int RS_LSB = OP_LSB - REG_AW;
   localparam int RT_LSB = RS_LSB - REG_AW;
   localparam int RD_LSB = RT_LSB - REG_AW;
   localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

   logic [3:0]        f_op;
   logic [REG_AW-1:0] f_rs, f_rt, f_rd, dest;
   logic              legal, r_fmt, uses_rt;
   logic              d_rw, d_dst, d_srca, d_srcb, d_mw, d_m2r;
   logic [2:0]        d_aluop;
   logic [NREG-1:0]   clr, set, eff;
   logic              hazard, ready, accept;

   assign f_op = bus.instruction[INSTR_W-1:OP_LSB];
   assign f_rs = bus.instruction[RS_LSB +: REG_AW];
   assign f_rt = bus.instruction[RT_LSB +: REG_AW];
   assign f_rd = bus.instruction[RD_LSB +: REG_AW];

   always_comb begin
      legal   = 1'b1;
      r_fmt   = 1'b0;
      uses_rt = 1'b0;
      d_rw    = 1'b0;
      d_dst   = 1'b0;
      d_srca  = 1'b0;
      d_srcb  = 1'b0;
      d_mw    = 1'b0;
      d_m2r   = 1'b0;
      d_aluop = 3'b000;
      case (f_op)
         4'h0: begin d_rw = 1'b1; d_srcb = 1'b1; d_m2r = 1'b1; end
         4'h1: begin uses_rt = 1'b1; d_srcb = 1'b1; d_mw = 1'b1; end
         4'h2: begin r_fmt = 1'b1; uses_rt = 1'b1; d_rw = 1'b1; d_dst = 1'b1; end
         4'h3: begin d_rw = 1'b1; d_srcb = 1'b1; end
         4'h4: begin r_fmt = 1'b1; uses_rt = 1'b1; d_rw = 1'b1; d_dst = 1'b1;
                     d_srca = 1'b1; d_aluop = 3'b001; end
         4'h5: begin r_fmt = 1'b1; uses_rt = 1'b1; d_rw = 1'b1; d_dst = 1'b1;
                     d_aluop = 3'b010; end
         4'h6: begin d_rw = 1'b1; d_srcb = 1'b1; d_aluop = 3'b010; end
         4'h7: begin r_fmt = 1'b1; uses_rt = 1'b1; d_rw = 1'b1; d_dst = 1'b1;
                     d_aluop = 3'b011; end
         4'h8: begin d_rw = 1'b1; d_srcb = 1'b1; d_aluop = 3'b011; end
         4'h9: begin d_rw = 1'b1; d_srcb = 1'b1; d_aluop = 3'b100; end
         4'hA: begin d_rw = 1'b1; d_srcb = 1'b1; d_aluop = 3'b101; end
         4'hB: begin uses_rt = 1'b1; d_aluop = 3'b110; end
         4'hC: begin uses_rt = 1'b1; d_aluop = 3'b111; end
         4'hD: begin r_fmt = 1'b1; uses_rt = 1'b1; d_rw = 1'b1; d_srca = 1'b1;
                     d_aluop = 3'b010; end
         default: legal = 1'b0;
      endcase
   end

   assign dest = d_dst ? f_rd : f_rt;

   // A writeback landing this cycle releases its register for the incoming instruction.
   assign clr    = bus.wb_valid ? (ONE << bus.wb_addr) : '0;
   assign eff    = bus.pending & ~clr;
   assign hazard = legal && (eff[f_rs] || (uses_rt && eff[f_rt]) || (d_rw && eff[dest]));
   assign ready  = !rst && !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
   assign accept = bus.in_valid && ready;
   assign set    = (accept && legal && d_rw) ? (ONE << dest) : '0;

   assign bus.in_ready = ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid    <= 1'b0;
         bus.reg_write    <= 1'b0;
         bus.reg_dst      <= 1'b0;
         bus.alu_src_a    <= 1'b0;
         bus.alu_src_b    <= 1'b0;
         bus.mem_write    <= 1'b0;
         bus.mem_to_reg   <= 1'b0;
         bus.alu_op       <= 3'b000;
         bus.opcode       <= 4'h0;
         bus.rs_addr      <= '0;
         bus.rt_addr      <= '0;
         bus.rd_addr      <= '0;
         bus.imm          <= '0;
         bus.illegal_seen <= 1'b0;
         bus.pending      <= '0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
         bus.pending   <= '0;
      end else begin
         if (accept && legal) begin
            bus.out_valid  <= 1'b1;
            bus.reg_write  <= d_rw;
            bus.reg_dst    <= d_dst;
            bus.alu_src_a  <= d_srca;
            bus.alu_src_b  <= d_srcb;
            bus.mem_write  <= d_mw;
            bus.mem_to_reg <= d_m2r;
            bus.alu_op     <= d_aluop;
            bus.opcode     <= f_op;
            bus.rs_addr    <= f_rs;
            bus.rt_addr    <= f_rt;
            bus.rd_addr    <= r_fmt ? f_rd : '0;
            bus.imm        <= r_fmt ? '0 : bus.instruction[IMM_W-1:0];
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
         if (accept && !legal) begin
            bus.illegal_seen <= 1'b1;
         end
         bus.pending <= (bus.pending & ~clr) | set;
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   decode_stage_if #(.INSTR_W(16), .REG_AW(2)) bus ();

   decode_stage #(.INSTR_W(16), .REG_AW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid    = 1'b1;
      bus.instruction = 16'h2180;
      bus.out_ready   = 1'b1;
      bus.wb_valid    = 1'b0;
      bus.wb_addr     = 2'd0;
      bus.flush       = 1'b1;
      tick();
      tick();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_reg_write", bus.reg_write, 0);
      check("rst_opcode", bus.opcode, 0);
      check("rst_pending", bus.pending, 0);
      check("rst_illegal", bus.illegal_seen, 0);
      check("rst_in_ready", bus.in_ready, 0);

      rst = 1'b0;
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("post_rst_in_ready", bus.in_ready, 1);

      // R op2 rs=0 rt=1 rd=2
      bus.in_valid = 1'b1;
      bus.instruction = 16'h2180;
      tick();
      check("r2_out_valid", bus.out_valid, 1);
      check("r2_reg_write", bus.reg_write, 1);
      check("r2_reg_dst", bus.reg_dst, 1);
      check("r2_rd", bus.rd_addr, 2);
      check("r2_rt", bus.rt_addr, 1);
      check("r2_alu_op", bus.alu_op, 3'b000);
      check("r2_imm", bus.imm, 0);
      check("r2_pending", bus.pending, 4'b0100);

      // RAW: op3 rs=2 rt=3 imm=5
      bus.instruction = 16'h3B05;
      #1;
      check("raw_stall", bus.in_ready, 0);
      tick();
      check("raw_drain", bus.out_valid, 0);
      bus.wb_valid = 1'b1;
      bus.wb_addr = 2'd2;
      #1;
      check("raw_bypass_ready", bus.in_ready, 1);
      tick();
      bus.wb_valid = 1'b0;
      bus.in_valid = 1'b0;
      check("raw_pending", bus.pending, 4'b1000);
      check("raw_out_valid", bus.out_valid, 1);
      check("raw_opcode", bus.opcode, 3);
      check("raw_rd_zero", bus.rd_addr, 0);
      check("raw_imm", bus.imm, 8'h05);
      check("raw_src_b", bus.alu_src_b, 1);
      check("raw_reg_dst", bus.reg_dst, 0);

      bus.wb_valid = 1'b1;
      bus.wb_addr = 2'd3;
      tick();
      bus.wb_valid = 1'b0;
      check("wb_clear", bus.pending, 0);
      check("wb_out_drop", bus.out_valid, 0);

      // backpressure: op5 rd=1 then op7 rs=2 rt=2 rd=3
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.instruction = 16'h5040;
      tick();
      check("bp_first_valid", bus.out_valid, 1);
      check("bp_first_alu", bus.alu_op, 3'b010);
      check("bp_first_pending", bus.pending, 4'b0010);
      bus.instruction = 16'h7AC0;
      #1;
      check("bp_stall", bus.in_ready, 0);
      tick();
      check("bp_hold_opcode", bus.opcode, 5);
      check("bp_hold_rd", bus.rd_addr, 1);
      check("bp_hold_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_ready", bus.in_ready, 1);
      tick();
      check("bp_second_opcode", bus.opcode, 7);
      check("bp_second_alu", bus.alu_op, 3'b011);
      check("bp_second_rd", bus.rd_addr, 3);
      check("bp_pending", bus.pending, 4'b1010);

      // illegal opcode consumed
      bus.instruction = 16'hE123;
      #1;
      check("ill_ready", bus.in_ready, 1);
      tick();
      check("ill_out_valid", bus.out_valid, 0);
      check("ill_seen", bus.illegal_seen, 1);
      check("ill_pending", bus.pending, 4'b1010);

      // opB: no register write
      bus.instruction = 16'hB000;
      tick();
      check("b_out_valid", bus.out_valid, 1);
      check("b_reg_write", bus.reg_write, 0);
      check("b_alu", bus.alu_op, 3'b110);
      check("b_pending", bus.pending, 4'b1010);

      // flush
      bus.flush = 1'b1;
      bus.out_ready = 1'b0;
      bus.instruction = 16'h3005;
      #1;
      check("flush_ready", bus.in_ready, 0);
      tick();
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      check("flush_pending", bus.pending, 0);
      check("flush_out_valid", bus.out_valid, 0);
      check("flush_illegal_kept", bus.illegal_seen, 1);

      // reset beats flush and in_valid
      rst = 1'b1;
      bus.flush = 1'b1;
      bus.instruction = 16'h2180;
      tick();
      check("rst2_out_valid", bus.out_valid, 0);
      check("rst2_pending", bus.pending, 0);
      check("rst2_illegal", bus.illegal_seen, 0);
      check("rst2_opcode", bus.opcode, 0);
      check("rst2_rd", bus.rd_addr, 0);
      rst = 1'b0;
      bus.flush = 1'b0;

      // back-to-back throughput: STORE then op4 rd=1
      bus.instruction = 16'h1000;
      #1;
      check("tp_ready1", bus.in_ready, 1);
      tick();
      check("tp_store_mw", bus.mem_write, 1);
      check("tp_store_opcode", bus.opcode, 1);
      bus.instruction = 16'h4040;
      #1;
      check("tp_ready2", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      check("tp_op4_srca", bus.alu_src_a, 1);
      check("tp_op4_alu", bus.alu_op, 3'b001);
      check("tp_op4_pending", bus.pending, 4'b0010);
      check("tp_op4_valid", bus.out_valid, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage with a register scoreboard.
- Sits between fetch and execute. Decodes the 16-opcode ISA into the ALU/memory control bundle.
- Holds back instructions with RAW/WAW hazards until writeback clears them.
- Generalises the combinational decoder: parametric field widths, valid/ready flow control, illegal-opcode detection, flush.

Parameters:
- INSTR_W, 16, instruction width.
- REG_AW, 2, register address width; NREG = 2**REG_AW.
- IMM_W, INSTR_W-4-2*REG_AW (8 at defaults), immediate width; must be >= 3*REG_AW-2*REG_AW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- instruction  in  INSTR_W  opcode=[W-1:W-4], rs=next REG_AW bits, rt=next REG_AW, rd=next REG_AW, imm=low IMM_W.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- reg_write, reg_dst, alu_src_a, alu_src_b, mem_write, mem_to_reg  out  1 each  control bits.
- alu_op  out  3  ALU operation.
- opcode  out  4  registered opcode.
- rs_addr, rt_addr, rd_addr  out  REG_AW each  register fields.
- imm  out  IMM_W  immediate (0 for R-format).
- wb_valid  in  1  writeback completes.
- wb_addr  in  REG_AW  register written back.
- flush  in  1  discard in-flight state.
- illegal_seen  out  1  sticky illegal-opcode flag.
- pending  out  NREG  scoreboard bits.

Behaviour:
- Reset: all outputs 0, pending=0, illegal_seen=0. Priority: rst > flush > normal.
- Formats:
  - R-format: rs, rt, rd from fields; imm=0.
  - I-format: rs, rt from fields; rd=0; imm=low IMM_W bits.
- Decode table, listed as op: fmt rw dst srcA srcB aluop mw m2r.
  - 0 LOAD: I 1 0 0 1 000 0 1
  - 1 STORE: I 0 0 0 1 000 1 0
  - 2: R 1 1 0 0 000 0 0
  - 3: I 1 0 0 1 000 0 0
  - 4: R 1 1 1 0 001 0 0
  - 5: R 1 1 0 0 010 0 0
  - 6: I 1 0 0 1 010 0 0
  - 7: R 1 1 0 0 011 0 0
  - 8: I 1 0 0 1 011 0 0
  - 9: I 1 0 0 1 100 0 0
  - A: I 1 0 0 1 101 0 0
  - B: I 0 0 0 0 110 0 0
  - C: I 0 0 0 0 111 0 0
  - D: R 1 0 1 0 010 0 0
  - E, F: illegal.
- Destination: dest = reg_dst ? rd : rt.
- Register usage:
  - rs is read by all legal ops.
  - rt is read by ops 1, 2, 4, 5, 7, B, C, D.
- Effective pending: eff = pending & ~(wb_valid ? onehot(wb_addr) : 0). Same-cycle writeback bypass.
- hazard = legal && (eff[rs] || (uses_rt && eff[rt]) || (reg_write && eff[dest])).
- Handshake:
  - in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
  - Accept when in_valid && in_ready.
  - in_ready may depend combinationally on instruction; the upstream must hold instruction stable while in_valid && !in_ready.
- Legal accept: the bundle registers on the next edge (latency 1), out_valid=1, and pending[dest] is set if reg_write.
- Illegal accept: the instruction is consumed; out_valid is cleared if the held bundle was taken; illegal_seen=1 until rst; pending is unchanged.
- Bundle held stable while out_valid && !out_ready. Out_valid drops after the handshake if there is no new accept.
- Pending update per edge: pending <= (pending & ~clr) | set. Set wins when the same register is cleared and set.
- wb_valid for a non-pending register: no effect.
- flush: out_valid <= 0, pending <= 0, no accept that cycle, illegal_seen kept.
- Throughput: 1 instruction/cycle with no hazards and out_ready=1.

Test Plan:
- Reset → all outputs 0; in_ready=1 the cycle after rst drops.
- Issue 0x2_1_8 (R op2, rs=0, rt=1, rd=2) → next cycle: out_valid=1, reg_write=1, reg_dst=1, rd_addr=2, alu_op=000, pending=4'b0100.
- RAW: issue op2 writing r2, then op3 with rs=2 → in_ready=0. Pulse wb_valid with wb_addr=2 → same cycle in_ready=1 and op3 accepted; pending[2]=0 and pending[rt of op3]=1 next cycle.
- Backpressure: hold out_ready=0 across two issues → second is stalled (in_ready=0), first bundle unchanged. Raise out_ready → second bundle appears one cycle later.
- Illegal: instruction 0xE123 → accepted, out_valid stays 0, illegal_seen=1 and stays 1 through a flush; cleared only by rst.
- flush with pending=4'b1010 and out_valid=1 → next cycle pending=0, out_valid=0. rst asserted with flush and in_valid → all outputs 0.
